// File: rtl/front_panel_ctrl_pkg.sv
// Shared definitions for the front-panel controller: parameter defaults,
// FSM state encoding and the event priority order.
package front_panel_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int AW_DEF              = 12;
  localparam int DW_DEF              = 12;

  // Event slots in priority order: the lowest index wins a same-cycle tie.
  localparam int EV_HALT   = 0;
  localparam int EV_RUN    = 1;
  localparam int EV_SST    = 2;
  localparam int EV_LDADDR = 3;
  localparam int EV_DEP    = 4;
  localparam int EV_EXAM   = 5;
  localparam int NUM_EV    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EX_SETUP,
    ST_EX_READ,
    ST_DP_SETUP,
    ST_DP_WRITE,
    ST_DP_HOLD
  } state_t;

  function automatic logic is_examine(state_t s);
    return (s == ST_EX_SETUP) || (s == ST_EX_READ);
  endfunction

  function automatic logic is_deposit(state_t s);
    return (s == ST_DP_SETUP) || (s == ST_DP_WRITE) || (s == ST_DP_HOLD);
  endfunction

endpackage

// File: rtl/front_panel_ctrl_if.sv
// Shared RAM bus as seen by the panel: the panel is the master while it owns
// the bus, the RAM side is the slave.
interface front_panel_ctrl_if #(
  parameter int AW = 12,
  parameter int DW = 12
);
  logic          busEn;
  logic [AW-1:0] busAddr;
  logic [DW-1:0] busDout;
  logic          busOe;
  logic          busWe;
  logic [DW-1:0] busDin;

  modport master (output busEn, busAddr, busDout, busOe, busWe, input busDin);
  modport slave  (input busEn, busAddr, busDout, busOe, busWe, output busDin);
endinterface

// File: rtl/panel_debounce.sv
// One panel button: two-flop synchronizer, stability counter, arm flag and a
// single-cycle event on each armed rising edge of the debounced level.
module panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic event_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    fill_q, fill_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          event_q, event_d;

  // fill_q marks when sync2_q holds a real sample, so a button held through
  // reset is never mistaken for a released one and never gets armed.
  always_comb begin
    fill_d  = {fill_q[0], 1'b1};
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    armed_d = armed_q | (fill_q[1] & ~sync2_q & ~level_q);
    event_d = level_d & ~level_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      fill_q  <= fill_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      event_q <= event_d;
    end
  end

  assign event_pulse = event_q;

endmodule

// File: rtl/front_panel_ctrl.sv
// PDP-8 front panel: debounced buttons become run-control strobes, and the
// Load-Address / Examine / Deposit cycles borrow the RAM bus while halted.
module front_panel_ctrl
  import front_panel_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int AW              = AW_DEF,
  parameter int DW              = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               running,
  input  logic               btnRun,
  input  logic               btnSst,
  input  logic               btnHalt,
  input  logic               btnLdAddr,
  input  logic               btnDep,
  input  logic               btnExam,
  input  logic [DW-1:0]      swSR,
  output logic               startstop,
  output logic               sst,
  output logic               halt,
  output logic               ldPc,
  output logic [AW-1:0]      pcValue,
  front_panel_ctrl_if.master bus,
  output logic [AW-1:0]      cpma,
  output logic [DW-1:0]      dispData,
  output logic               busy,
  output logic               rejected
);

  logic [NUM_EV-1:0] btn_raw;
  logic [NUM_EV-1:0] ev;

  assign btn_raw[EV_HALT]   = btnHalt;
  assign btn_raw[EV_RUN]    = btnRun;
  assign btn_raw[EV_SST]    = btnSst;
  assign btn_raw[EV_LDADDR] = btnLdAddr;
  assign btn_raw[EV_DEP]    = btnDep;
  assign btn_raw[EV_EXAM]   = btnExam;

  for (genvar i = 0; i < NUM_EV; i++) begin : g_deb
    panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .event_pulse(ev[i])
    );
  end

  state_t            state_q, state_d;
  logic [AW-1:0]     cpma_q, cpma_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic [DW-1:0]     data_q, data_d;
  logic              startstop_q, startstop_d;
  logic              sst_q, sst_d;
  logic              halt_q, halt_d;
  logic              ldpc_q, ldpc_d;
  logic              rejected_q, rejected_d;

  logic              win_found;
  int                win_idx;
  logic [NUM_EV-1:0] dropped;
  logic              idle;
  logic              mem_ok;

  // Priority pick among same-cycle events, acceptance rules, then the memory
  // cycle sequencing; a rise of running aborts any panel cycle in flight.
  always_comb begin
    state_d     = state_q;
    cpma_d      = cpma_q;
    pc_d        = pc_q;
    disp_d      = disp_q;
    data_d      = data_q;
    startstop_d = 1'b0;
    sst_d       = 1'b0;
    halt_d      = 1'b0;
    ldpc_d      = 1'b0;
    rejected_d  = 1'b0;
    win_found   = 1'b0;
    win_idx     = 0;
    dropped     = ev;
    idle        = (state_q == ST_IDLE);
    mem_ok      = idle && !running;

    for (int i = 0; i < NUM_EV; i++) begin
      if (ev[i] && !win_found) begin
        win_found  = 1'b1;
        win_idx    = i;
        dropped[i] = 1'b0;
      end
    end
    if (|dropped) rejected_d = 1'b1;

    if (win_found) begin
      case (win_idx)
        EV_HALT: halt_d = 1'b1;
        EV_RUN: begin
          if (idle) startstop_d = 1'b1;
          else      rejected_d  = 1'b1;
        end
        EV_SST: begin
          if (idle) sst_d      = 1'b1;
          else      rejected_d = 1'b1;
        end
        EV_LDADDR: begin
          if (mem_ok) begin
            cpma_d = AW'(swSR);
            pc_d   = AW'(swSR);
            ldpc_d = 1'b1;
          end else begin
            rejected_d = 1'b1;
          end
        end
        EV_DEP: begin
          if (mem_ok) begin
            data_d  = swSR;
            state_d = ST_DP_SETUP;
          end else begin
            rejected_d = 1'b1;
          end
        end
        EV_EXAM: begin
          if (mem_ok) state_d    = ST_EX_SETUP;
          else        rejected_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (!idle && running) begin
      state_d    = ST_IDLE;
      rejected_d = 1'b1;
    end else begin
      case (state_q)
        ST_EX_SETUP: state_d = ST_EX_READ;
        ST_EX_READ: begin
          disp_d  = bus.busDin;
          cpma_d  = cpma_q + 1'b1;
          state_d = ST_IDLE;
        end
        ST_DP_SETUP: state_d = ST_DP_WRITE;
        ST_DP_WRITE: state_d = ST_DP_HOLD;
        ST_DP_HOLD: begin
          disp_d  = data_q;
          cpma_d  = cpma_q + 1'b1;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cpma_q      <= '0;
      pc_q        <= '0;
      disp_q      <= '0;
      data_q      <= '0;
      startstop_q <= 1'b0;
      sst_q       <= 1'b0;
      halt_q      <= 1'b0;
      ldpc_q      <= 1'b0;
      rejected_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpma_q      <= cpma_d;
      pc_q        <= pc_d;
      disp_q      <= disp_d;
      data_q      <= data_d;
      startstop_q <= startstop_d;
      sst_q       <= sst_d;
      halt_q      <= halt_d;
      ldpc_q      <= ldpc_d;
      rejected_q  <= rejected_d;
    end
  end

  // Bus drive decodes straight from the state register; every non-IDLE state
  // is a memory state, so ownership is simply "not idle".
  logic bus_en;
  assign bus_en      = (state_q != ST_IDLE);
  assign bus.busEn   = bus_en;
  assign bus.busOe   = is_examine(state_q);
  assign bus.busWe   = (state_q == ST_DP_WRITE);
  assign bus.busAddr = bus_en ? cpma_q : '0;
  assign bus.busDout = is_deposit(state_q) ? data_q : '0;

  assign startstop = startstop_q;
  assign sst       = sst_q;
  assign halt      = halt_q;
  assign ldPc      = ldpc_q;
  assign pcValue   = pc_q;
  assign cpma      = cpma_q;
  assign dispData  = disp_q;
  assign busy      = bus_en;
  assign rejected  = rejected_q;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Bench for front_panel_ctrl: a behavioural panel model checked every cycle,
// plus directed button sequences with hand-computed results.
module tb_front_panel_ctrl;

  localparam int D  = 16;
  localparam int AW = 12;
  localparam int DW = 12;

  localparam int B_HALT = 0;
  localparam int B_RUN  = 1;
  localparam int B_SST  = 2;
  localparam int B_LD   = 3;
  localparam int B_DEP  = 4;
  localparam int B_EXAM = 5;

  logic          clk;
  logic          reset;
  logic          running;
  logic [5:0]    btn;
  logic [DW-1:0] swSR;
  logic          startstop, sst, halt, ldPc;
  logic [AW-1:0] pcValue, cpma;
  logic [DW-1:0] dispData;
  logic          busy, rejected;

  front_panel_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  front_panel_ctrl #(.DEBOUNCE_CYCLES(D), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .running  (running),
    .btnRun   (btn[B_RUN]),
    .btnSst   (btn[B_SST]),
    .btnHalt  (btn[B_HALT]),
    .btnLdAddr(btn[B_LD]),
    .btnDep   (btn[B_DEP]),
    .btnExam  (btn[B_EXAM]),
    .swSR     (swSR),
    .startstop(startstop),
    .sst      (sst),
    .halt     (halt),
    .ldPc     (ldPc),
    .pcValue  (pcValue),
    .bus      (bus),
    .cpma     (cpma),
    .dispData (dispData),
    .busy     (busy),
    .rejected (rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents before any write follow a simple address pattern.
  function automatic logic [11:0] initWord(int a);
    return 12'((a * 5 + 'o1234) % 4096);
  endfunction

  logic [DW-1:0] ram [0:4095];
  bit            ramWr [0:4095];

  function automatic logic [11:0] readRam(int a);
    return ramWr[a] ? ram[a] : initWord(a);
  endfunction

  assign bus.busDin = ramWr[bus.busAddr] ? ram[bus.busAddr] : initWord(int'(bus.busAddr));

  always @(posedge clk) begin
    if (bus.busWe) begin
      ram[bus.busAddr]   <= bus.busDout;
      ramWr[bus.busAddr] <= 1'b1;
    end
  end

  int testsRun;
  int failures;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Panel model: buttons, debouncing and memory cycles described as stable
  // run lengths, a pending event list and a step counter per memory operation.
  int            cycleCount;
  bit            modelValid;
  logic [5:0]    mRaw1, mRaw2, mLvl, mArmed, mEv;
  int            mRun [6];
  int            mEdges;
  int            mOp;
  int            mStep;
  logic [AW-1:0] mCpma, mPc;
  logic [DW-1:0] mDisp, mData;
  logic [DW-1:0] mMem [0:4095];
  bit            eStartstop, eSst, eHalt, eLdPc, eRej;

  task automatic modelStep();
    logic [5:0] ev;
    bit         s, lvlOld, rose, wasBusy;
    int         win;
    cycleCount++;
    if (reset) begin
      mRaw1 = '0; mRaw2 = '0; mLvl = '0; mArmed = '0; mEv = '0;
      foreach (mRun[i]) mRun[i] = 0;
      mEdges = 0;
      mOp = 0; mStep = 0;
      mCpma = '0; mPc = '0; mDisp = '0; mData = '0;
      eStartstop = 0; eSst = 0; eHalt = 0; eLdPc = 0; eRej = 0;
      modelValid = 1'b1;
      return;
    end
    ev = mEv;
    for (int b = 0; b < 6; b++) begin
      s      = mRaw2[b];
      lvlOld = mLvl[b];
      rose   = 0;
      if (s == lvlOld) mRun[b] = 0;
      else begin
        mRun[b]++;
        if (mRun[b] == D) begin
          mLvl[b] = s;
          mRun[b] = 0;
          rose    = s;
        end
      end
      mEv[b] = rose && mArmed[b];
      if (mEdges >= 2 && !s && !lvlOld) mArmed[b] = 1'b1;
      mRaw2[b] = mRaw1[b];
      mRaw1[b] = btn[b];
    end
    mEdges++;

    eStartstop = 0; eSst = 0; eHalt = 0; eLdPc = 0; eRej = 0;
    wasBusy = (mOp != 0);
    if (wasBusy) begin
      if (running) begin
        mOp  = 0;
        eRej = 1;
      end else begin
        mStep++;
        if (mOp == 1 && mStep == 2) begin
          mDisp = mMem[mCpma];
          mCpma++;
          mOp = 0;
        end else if (mOp == 2 && mStep == 3) begin
          mMem[mCpma] = mData;
          mDisp = mData;
          mCpma++;
          mOp = 0;
        end
      end
    end
    win = -1;
    for (int b = 0; b < 6; b++) begin
      if (ev[b]) begin
        if (win < 0) win = b;
        else eRej = 1;
      end
    end
    case (win)
      B_HALT: eHalt = 1;
      B_RUN:  if (wasBusy) eRej = 1; else eStartstop = 1;
      B_SST:  if (wasBusy) eRej = 1; else eSst = 1;
      B_LD: begin
        if (wasBusy || running) eRej = 1;
        else begin mCpma = swSR; mPc = swSR; eLdPc = 1; end
      end
      B_DEP: begin
        if (wasBusy || running) eRej = 1;
        else begin mOp = 2; mStep = 0; mData = swSR; end
      end
      B_EXAM: begin
        if (wasBusy || running) eRej = 1;
        else begin mOp = 1; mStep = 0; end
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  task automatic compareAll();
    checkOutput("startstop", 32'(startstop), 32'(eStartstop));
    checkOutput("sst", 32'(sst), 32'(eSst));
    checkOutput("halt", 32'(halt), 32'(eHalt));
    checkOutput("ldPc", 32'(ldPc), 32'(eLdPc));
    checkOutput("rejected", 32'(rejected), 32'(eRej));
    checkOutput("pcValue", 32'(pcValue), 32'(mPc));
    checkOutput("cpma", 32'(cpma), 32'(mCpma));
    checkOutput("dispData", 32'(dispData), 32'(mDisp));
    checkOutput("busy", 32'(busy), 32'(mOp != 0));
    checkOutput("busEn", 32'(bus.busEn), 32'(mOp != 0));
    checkOutput("busOe", 32'(bus.busOe), 32'(mOp == 1));
    checkOutput("busWe", 32'(bus.busWe), 32'(mOp == 2 && mStep == 1));
    checkOutput("busAddr", 32'(bus.busAddr), (mOp != 0) ? 32'(mCpma) : 32'd0);
    checkOutput("busDout", 32'(bus.busDout), (mOp == 2) ? 32'(mData) : 32'd0);
  endtask

  int            busEnCycles, busWeCycles, ldPcCount, ldPcCycle;
  int            haltCount, startstopCount, sstCount, rejCount;
  logic [AW-1:0] lastBusAddr, lastWeAddr;
  logic [DW-1:0] lastWeData;

  initial begin
    forever begin
      @(negedge clk);
      if (modelValid) compareAll();
      if (bus.busEn) begin busEnCycles++; lastBusAddr = bus.busAddr; end
      if (bus.busWe) begin busWeCycles++; lastWeAddr = bus.busAddr; lastWeData = bus.busDout; end
      if (ldPc) begin ldPcCount++; ldPcCycle = cycleCount; end
      if (halt) haltCount++;
      if (startstop) startstopCount++;
      if (sst) sstCount++;
      if (rejected) rejCount++;
    end
  end

  task automatic clearCounters();
    busEnCycles = 0; busWeCycles = 0; ldPcCount = 0; ldPcCycle = -1;
    haltCount = 0; startstopCount = 0; sstCount = 0; rejCount = 0;
    lastBusAddr = '0; lastWeAddr = '0; lastWeData = '0;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int b, int hold, int settle);
    btn[b] = 1'b1;
    tick(hold);
    btn[b] = 1'b0;
    tick(settle);
  endtask

  task automatic waitBusEn(string name, int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (bus.busEn) seen = 1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  int pressCycle;

  initial begin
    for (int a = 0; a < 4096; a++) mMem[a] = initWord(a);
    reset   = 1'b1;
    running = 1'b0;
    btn     = '0;
    btn[B_EXAM] = 1'b1;
    swSR    = '0;
    clearCounters();
    tick(3);
    reset = 1'b0;

    // Exam held through reset: nothing happens until released and pressed.
    tick(40);
    checkOutput("held_exam_busEn", 32'(busEnCycles), 32'd0);
    checkOutput("held_exam_rej", 32'(rejCount), 32'd0);
    btn[B_EXAM] = 1'b0;
    tick(30);
    clearCounters();
    applyStimulus(B_EXAM, 18, 40);
    checkOutput("exam0_busEnCycles", 32'(busEnCycles), 32'd2);
    checkOutput("exam0_addr", 32'(lastBusAddr), 32'd0);
    checkOutput("exam0_cpma", 32'(cpma), 32'd1);
    checkOutput("exam0_disp", 32'(dispData), 'o1234);

    // Load address 0200 and check strobe timing, then deposit 7402 there.
    swSR = 12'o0200;
    clearCounters();
    pressCycle = cycleCount + 1;
    applyStimulus(B_LD, 18, 30);
    checkOutput("ld_count", 32'(ldPcCount), 32'd1);
    checkOutput("ld_cycle", 32'(ldPcCycle), 32'(pressCycle + 18));
    checkOutput("ld_pcValue", 32'(pcValue), 'o0200);
    checkOutput("ld_cpma", 32'(cpma), 'o0200);
    checkOutput("ld_busEn", 32'(busEnCycles), 32'd0);

    swSR = 12'o7402;
    clearCounters();
    applyStimulus(B_DEP, 18, 40);
    checkOutput("dep_weCycles", 32'(busWeCycles), 32'd1);
    checkOutput("dep_weAddr", 32'(lastWeAddr), 'o0200);
    checkOutput("dep_weData", 32'(lastWeData), 'o7402);
    checkOutput("dep_busEnCycles", 32'(busEnCycles), 32'd3);
    checkOutput("dep_cpma", 32'(cpma), 'o0201);
    checkOutput("dep_disp", 32'(dispData), 'o7402);
    checkOutput("dep_ram", 32'(readRam('o0200)), 'o7402);

    // Examine at 7777 wraps cpma to 0000.
    swSR = 12'o7777;
    applyStimulus(B_LD, 18, 30);
    clearCounters();
    applyStimulus(B_EXAM, 18, 40);
    checkOutput("wrap_addr", 32'(lastBusAddr), 'o7777);
    checkOutput("wrap_busEnCycles", 32'(busEnCycles), 32'd2);
    checkOutput("wrap_cpma", 32'(cpma), 32'd0);
    checkOutput("wrap_disp", 32'(dispData), 'o1227);

    // While running: deposit is refused, halt still strobes once.
    running = 1'b1;
    clearCounters();
    applyStimulus(B_DEP, 18, 40);
    checkOutput("run_dep_busEn", 32'(busEnCycles), 32'd0);
    checkOutput("run_dep_rej", 32'(rejCount), 32'd1);
    checkOutput("run_dep_cpma", 32'(cpma), 32'd0);
    clearCounters();
    applyStimulus(B_HALT, 18, 40);
    checkOutput("run_halt_count", 32'(haltCount), 32'd1);
    checkOutput("run_halt_rej", 32'(rejCount), 32'd0);
    running = 1'b0;

    // Run and halt together: halt wins, run is dropped.
    clearCounters();
    btn[B_RUN]  = 1'b1;
    btn[B_HALT] = 1'b1;
    tick(18);
    btn[B_RUN]  = 1'b0;
    btn[B_HALT] = 1'b0;
    tick(40);
    checkOutput("tie_halt", 32'(haltCount), 32'd1);
    checkOutput("tie_startstop", 32'(startstopCount), 32'd0);
    checkOutput("tie_rej", 32'(rejCount), 32'd1);

    // Short glitch is filtered; full presses of sst and run strobe once.
    clearCounters();
    applyStimulus(B_SST, 5, 40);
    checkOutput("glitch_sst", 32'(sstCount), 32'd0);
    applyStimulus(B_SST, 18, 40);
    checkOutput("sst_count", 32'(sstCount), 32'd1);
    applyStimulus(B_RUN, 18, 40);
    checkOutput("run_count", 32'(startstopCount), 32'd1);
    checkOutput("single_rej", 32'(rejCount), 32'd0);

    // running rises during DP_SETUP: cycle aborted, no write.
    swSR = 12'o0055;
    clearCounters();
    applyStimulus(B_DEP, 18, 0);
    waitBusEn("abort_wait_busEn", 10);
    running = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busEn", 32'(bus.busEn), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    tick(5);
    running = 1'b0;
    checkOutput("abort_we", 32'(busWeCycles), 32'd0);
    checkOutput("abort_cpma", 32'(cpma), 32'd0);
    checkOutput("abort_disp", 32'(dispData), 'o1227);
    checkOutput("abort_rej", 32'(rejCount), 32'd1);
    checkOutput("abort_ram", 32'(readRam(0)), 'o1234);

    // Reset during an examine releases the bus and clears the registers.
    applyStimulus(B_EXAM, 18, 0);
    waitBusEn("rst_wait_busEn", 10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_busEn", 32'(bus.busEn), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_disp", 32'(dispData), 32'd0);
    checkOutput("rst_cpma", 32'(cpma), 32'd0);
    tick(40);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
